// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Direct-mapped BTB with 2-bit saturating counters, plus an execute-stage
//   resolver for RV32I conditional branches, JAL and JALR.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_pc                       fetch PC to look up
//   pred_taken, pred_target     combinational prediction for if_pc
//   ex_valid, ex_instr, ex_pc   execute-stage instruction and its PC
//   rs1, rs2                    source operand values
//   ex_pred_taken/_target       prediction made at fetch for ex_instr
//   redirect_valid/_pc          registered one-cycle fetch redirect
//   resolved_taken              registered outcome of the last valid instruction
//   branch_count                saturating count of valid control instructions
//   mispredict_count            saturating count of mispredicts
module branch_predict_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             ex_valid,
    input  logic [31:0]      ex_instr,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             resolved_taken,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX - 2;

    typedef enum logic [1:0] {
        K_NONE,
        K_BRANCH,
        K_JAL,
        K_JALR
    } kind_e;

    // BTB storage: only the valid bits are reset
    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_target [BTB_ENTRIES];
    logic [1:0]             btb_ctr    [BTB_ENTRIES];

    // ------------------------------------------------------------------
    // Fetch-side lookup (reads pre-update contents on a same-cycle write)
    // ------------------------------------------------------------------
    logic [IDX-1:0] if_idx;
    logic           if_hit;

    assign if_idx = if_pc[IDX+1:2];

    always_comb begin
        if_hit      = btb_valid[if_idx] && (btb_tag[if_idx] == if_pc[XLEN-1:IDX+2]);
        pred_taken  = if_hit && btb_ctr[if_idx][1];
        pred_target = pred_taken ? btb_target[if_idx] : if_pc + XLEN'(4);
    end

    // ------------------------------------------------------------------
    // Execute-side decode and resolution
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    kind_e           kind;
    logic [XLEN-1:0] imm_b, imm_j, imm_i;
    logic            cond;
    logic            taken;
    logic            is_ctrl;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] next_pc;
    logic            mispredict;

    assign opcode = ex_instr[6:0];
    assign funct3 = ex_instr[14:12];

    assign imm_b = {{(XLEN-13){ex_instr[31]}}, ex_instr[31], ex_instr[7],
                    ex_instr[30:25], ex_instr[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){ex_instr[31]}}, ex_instr[31], ex_instr[19:12],
                    ex_instr[20], ex_instr[30:21], 1'b0};
    assign imm_i = {{(XLEN-12){ex_instr[31]}}, ex_instr[31:20]};

    always_comb begin
        kind = K_NONE;
        case (opcode)
            7'b1100011: if (funct3 != 3'b010 && funct3 != 3'b011) kind = K_BRANCH;
            7'b1101111: kind = K_JAL;
            7'b1100111: if (funct3 == 3'b000) kind = K_JALR;
            default:    kind = K_NONE;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = (rs1 == rs2);
            3'b001:  cond = (rs1 != rs2);
            3'b100:  cond = ($signed(rs1) <  $signed(rs2));
            3'b101:  cond = ($signed(rs1) >= $signed(rs2));
            3'b110:  cond = (rs1 <  rs2);
            3'b111:  cond = (rs1 >= rs2);
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        is_ctrl  = (kind != K_NONE);
        taken    = (kind == K_BRANCH) ? cond : (kind == K_JAL || kind == K_JALR);
        jalr_sum = rs1 + imm_i;
        if (kind == K_JALR)
            target = {jalr_sum[XLEN-1:1], 1'b0};
        else
            target = ex_pc + ((kind == K_JAL) ? imm_j : imm_b);
        seq_pc  = ex_pc + XLEN'(4);
        next_pc = taken ? target : seq_pc;
        if (!ex_valid)
            mispredict = 1'b0;
        else if (is_ctrl)
            mispredict = (taken != ex_pred_taken) || (taken && (target != ex_pred_target));
        else
            mispredict = ex_pred_taken;
    end

    // ------------------------------------------------------------------
    // BTB update decision
    // ------------------------------------------------------------------
    logic [IDX-1:0]   ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic [1:0]       ex_ctr;
    logic             btb_wr;
    logic             btb_inval;
    logic [1:0]       wr_ctr;
    logic [XLEN-1:0]  wr_target;

    assign ex_idx = ex_pc[IDX+1:2];
    assign ex_tag = ex_pc[XLEN-1:IDX+2];
    assign ex_ctr = btb_ctr[ex_idx];
    assign ex_hit = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);

    always_comb begin
        btb_wr    = 1'b0;
        btb_inval = 1'b0;
        wr_ctr    = ex_ctr;
        wr_target = target;
        if (ex_valid) begin
            case (kind)
                K_BRANCH: begin
                    if (ex_hit) begin
                        btb_wr = 1'b1;
                        if (taken)
                            wr_ctr = (ex_ctr == 2'b11) ? 2'b11 : ex_ctr + 2'b01;
                        else
                            wr_ctr = (ex_ctr == 2'b00) ? 2'b00 : ex_ctr - 2'b01;
                        // a not-taken hit keeps the stored target
                        if (!taken) wr_target = btb_target[ex_idx];
                    end else if (taken) begin
                        btb_wr = 1'b1;
                        wr_ctr = 2'b10;
                    end
                end
                K_JAL, K_JALR: begin
                    btb_wr = 1'b1;
                    wr_ctr = 2'b11;
                end
                default: btb_inval = ex_pred_taken && ex_hit;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid <= '0;
        end else if (btb_wr) begin
            btb_valid[ex_idx] <= 1'b1;
        end else if (btb_inval) begin
            btb_valid[ex_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (btb_wr) begin
            btb_tag[ex_idx]    <= ex_tag;
            btb_target[ex_idx] <= wr_target;
            btb_ctr[ex_idx]    <= wr_ctr;
        end
    end

    // ------------------------------------------------------------------
    // Redirect, outcome and statistics registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            resolved_taken   <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            redirect_valid <= mispredict;
            if (mispredict)
                redirect_pc <= next_pc;
            if (ex_valid)
                resolved_taken <= taken;
            if (ex_valid && is_ctrl && branch_count != '1)
                branch_count <= branch_count + CNT_W'(1);
            if (mispredict && mispredict_count != '1)
                mispredict_count <= mispredict_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_instr;
    logic [31:0] ex_pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        resolved_taken;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    // narrow-counter instance sharing the same inputs, for saturation
    logic        s_pred_taken;
    logic [31:0] s_pred_target;
    logic        s_redirect_valid;
    logic [31:0] s_redirect_pc;
    logic        s_resolved_taken;
    logic [1:0]  s_branch_count;
    logic [1:0]  s_mispredict_count;

    always #5 clk = ~clk;

    branch_predict_unit #(.XLEN(32), .BTB_ENTRIES(64), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc(ex_pc),
        .rs1(rs1), .rs2(rs2),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .resolved_taken(resolved_taken),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    branch_predict_unit #(.XLEN(32), .BTB_ENTRIES(64), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .pred_taken(s_pred_taken), .pred_target(s_pred_target),
        .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc(ex_pc),
        .rs1(rs1), .rs2(rs2),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
        .resolved_taken(s_resolved_taken),
        .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
    );

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // instruction meaning as intended by the stimulus (0 none,1 branch,2 jal,3 jalr)
    int          st_kind;
    int          st_f3;
    logic [31:0] st_imm;

    bit          m_v   [64];
    logic [31:0] m_tag [64];
    logic [31:0] m_tgt [64];
    int          m_ctr [64];
    bit          m_rv;
    logic [31:0] m_rpc;
    bit          m_rt;
    longint      m_bc;
    longint      m_mc;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic void lookup(input logic [31:0] pc, output bit t, output logic [31:0] tg);
        int i = idx_of(pc);
        t  = m_v[i] && (m_tag[i] == pc / 256) && (m_ctr[i] >= 2);
        tg = t ? m_tgt[i] : pc + 4;
    endfunction

    task automatic model_exec();
        int          i   = idx_of(ex_pc);
        logic [31:0] tag = ex_pc / 256;
        bit          hit = m_v[i] && (m_tag[i] == tag);
        bit          ctl = (st_kind != 0);
        bit          tk  = 0;
        bit          mp;
        logic [31:0] tgt;
        logic [31:0] nxt;
        case (st_kind)
            1: case (st_f3)
                   0: tk = (rs1 == rs2);
                   1: tk = (rs1 != rs2);
                   4: tk = ($signed(rs1) <  $signed(rs2));
                   5: tk = ($signed(rs1) >= $signed(rs2));
                   6: tk = (rs1 <  rs2);
                   default: tk = (rs1 >= rs2);
               endcase
            2, 3: tk = 1;
            default: tk = 0;
        endcase
        tgt = (st_kind == 3) ? ((rs1 + st_imm) & 32'hFFFF_FFFE) : ex_pc + st_imm;
        nxt = tk ? tgt : ex_pc + 4;
        mp  = ctl ? (tk != ex_pred_taken || (tk && tgt != ex_pred_target)) : ex_pred_taken;
        if (ctl) m_bc++;
        if (mp) begin
            m_mc++;
            m_rv  = 1;
            m_rpc = nxt;
        end
        m_rt = tk;
        if (st_kind == 1) begin
            if (hit) begin
                m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                if (tk) m_tgt[i] = tgt;
            end else if (tk) begin
                m_v[i] = 1; m_tag[i] = tag; m_tgt[i] = tgt; m_ctr[i] = 2;
            end
        end else if (ctl) begin
            m_v[i] = 1; m_tag[i] = tag; m_tgt[i] = tgt; m_ctr[i] = 3;
        end else if (ex_pred_taken && hit) begin
            m_v[i] = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) m_v[i] = 0;
            m_rv = 0; m_rpc = '0; m_rt = 0; m_bc = 0; m_mc = 0;
        end else begin
            m_rv = 0;
            if (ex_valid) model_exec();
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit          et;
        logic [31:0] etg;
        if (chk_en) begin
            lookup(if_pc, et, etg);
            chk("pred_taken", 64'(pred_taken), 64'(et));
            chk("pred_target", 64'(pred_target), 64'(etg));
            chk("redirect_valid", 64'(redirect_valid), 64'(m_rv));
            chk("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
            chk("resolved_taken", 64'(resolved_taken), 64'(m_rt));
            chk("branch_count", 64'(branch_count), (m_bc > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(m_bc));
            chk("mispredict_count", 64'(mispredict_count), (m_mc > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(m_mc));
            chk("s_branch_count", 64'(s_branch_count), (m_bc > 3) ? 64'd3 : 64'(m_bc));
            chk("s_mispredict_count", 64'(s_mispredict_count), (m_mc > 3) ? 64'd3 : 64'(m_mc));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [31:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] imm);
        return {imm[11:0], 5'd1, f3, 5'd1, op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // drive one execute-stage instruction for one edge, then idle
    task automatic issue(input int kind, input int f3, input int imm, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit pt, input logic [31:0] ptgt);
        logic [31:0] iv = imm;
        case (kind)
            1: ex_instr = enc_b(3'(f3), iv);
            2: ex_instr = enc_j(iv);
            3: ex_instr = enc_i(7'b1100111, 3'b000, iv);
            default: ex_instr = (f3 == 2 || f3 == 3) ? enc_b(3'(f3), iv) : enc_i(7'b0010011, 3'b000, iv);
        endcase
        st_kind = kind; st_f3 = f3; st_imm = iv;
        ex_pc = pc; rs1 = a; rs2 = b; ex_pred_taken = pt; ex_pred_target = ptgt;
        ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc, input bit exp_t, input logic [31:0] exp_tg, input string nm);
        if_pc = pc;
        #1;
        chk({nm, "_taken"}, 64'(pred_taken), 64'(exp_t));
        chk({nm, "_target"}, 64'(pred_target), 64'(exp_tg));
    endtask

    initial begin
        bit          t;
        logic [31:0] tg;
        bit          outc [7] = '{1, 1, 0, 0, 0, 0, 1};
        int          f3s  [3] = '{1, 5, 7};

        ex_valid = 0; ex_instr = '0; ex_pc = '0; rs1 = '0; rs2 = '0;
        ex_pred_taken = 0; ex_pred_target = '0; if_pc = 32'h100;
        st_kind = 0; st_f3 = 0; st_imm = '0;

        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        #12 rst_n = 1'b1;
        look(32'h100, 0, 32'h104, "reset_lookup");
        chk("reset_redirect_valid", 64'(redirect_valid), 64'd0);
        chk("reset_mispredict_count", 64'(mispredict_count), 64'd0);
        tick();

        // first BEQ: miss, taken, predicted not taken
        issue(1, 0, 'h40, 32'h100, 5, 5, 0, 0);
        chk("beq1_redirect_valid", 64'(redirect_valid), 64'd1);
        chk("beq1_redirect_pc", 64'(redirect_pc), 64'h140);
        chk("beq1_mispredict_count", 64'(mispredict_count), 64'd1);
        chk("beq1_branch_count", 64'(branch_count), 64'd1);
        look(32'h100, 1, 32'h140, "beq1_lookup");

        issue(1, 0, 'h40, 32'h100, 5, 5, 1, 32'h140);
        chk("beq2_redirect_valid", 64'(redirect_valid), 64'd0);
        issue(1, 0, 'h40, 32'h100, 1, 2, 1, 32'h140);
        chk("beq3_redirect_valid", 64'(redirect_valid), 64'd1);
        chk("beq3_redirect_pc", 64'(redirect_pc), 64'h104);
        chk("beq3_branch_count", 64'(branch_count), 64'd3);
        look(32'h100, 1, 32'h140, "beq3_lookup");

        // counter walk 2->3->3->2->1->0->0->1
        for (int k = 0; k < 7; k++) begin
            lookup(32'h100, t, tg);
            issue(1, 0, 'h40, 32'h100, 7, outc[k] ? 32'd7 : 32'd8, t, tg);
        end
        look(32'h100, 0, 32'h104, "ctr_walk_lookup");

        // signed vs unsigned compares on 0xFFFFFFFF vs 1
        issue(1, 4, 8, 32'h180, 32'hFFFF_FFFF, 1, 0, 0);
        chk("blt_resolved", 64'(resolved_taken), 64'd1);
        chk("blt_redirect_pc", 64'(redirect_pc), 64'h188);
        issue(1, 6, 8, 32'h180, 32'hFFFF_FFFF, 1, 1, 32'h188);
        chk("bltu_resolved", 64'(resolved_taken), 64'd0);
        chk("bltu_redirect_pc", 64'(redirect_pc), 64'h184);
        foreach (f3s[k]) begin
            lookup(32'h180, t, tg);
            issue(1, f3s[k], 8, 32'h180, 32'hFFFF_FFFF, 1, t, tg);
        end

        // JALR clears bit 0 of rs1+imm
        issue(3, 0, 2, 32'h200, 32'h1001, 0, 0, 0);
        chk("jalr_redirect_pc", 64'(redirect_pc), 64'h1002);
        look(32'h200, 1, 32'h1002, "jalr_lookup");

        // JAL with negative offset, correctly predicted
        issue(2, 0, -'h100, 32'h400, 0, 0, 1, 32'h300);
        chk("jal_neg_redirect_valid", 64'(redirect_valid), 64'd0);
        // backward BNE
        issue(1, 1, -'h20, 32'h500, 1, 2, 0, 0);
        chk("bne_back_redirect_pc", 64'(redirect_pc), 64'h4E0);
        // address wrap
        issue(2, 0, 'h20, 32'hFFFF_FFF0, 0, 0, 0, 0);
        chk("jal_wrap_redirect_pc", 64'(redirect_pc), 64'h10);
        issue(1, 0, 'h40, 32'hFFFF_FFFC, 1, 2, 1, 32'h3C);
        chk("seq_wrap_redirect_pc", 64'(redirect_pc), 64'h0);

        // aliasing: same index as 0x100, different tag
        issue(1, 0, 'h40, 32'h10100, 3, 3, 0, 0);
        look(32'h100, 0, 32'h104, "alias_lookup");
        look(32'h10100, 1, 32'h10140, "alias_new_lookup");

        // branch funct3 010 is non-control
        issue(0, 2, 'h40, 32'h600, 1, 1, 0, 0);
        chk("f3_010_redirect_valid", 64'(redirect_valid), 64'd0);
        chk("f3_010_resolved", 64'(resolved_taken), 64'd0);

        // non-control with stale taken prediction invalidates the entry
        issue(2, 0, 'h80, 32'h300, 0, 0, 0, 0);
        issue(0, 0, 1, 32'h300, 0, 0, 1, 32'h380);
        chk("addi_redirect_pc", 64'(redirect_pc), 64'h304);
        look(32'h300, 0, 32'h304, "addi_inval_lookup");

        // ex_valid low: nothing changes
        ex_instr = enc_j(32'h40); ex_pc = 32'h200; ex_pred_taken = 1; ex_pred_target = 0;
        st_kind = 2; st_imm = 32'h40;
        tick();
        chk("idle_redirect_valid", 64'(redirect_valid), 64'd0);

        // reset between a mispredicting resolve and its edge
        st_kind = 2; st_f3 = 0; st_imm = 32'h40;
        ex_instr = enc_j(32'h40); ex_pc = 32'h240; ex_pred_taken = 0; ex_valid = 1;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_mid_redirect_valid", 64'(redirect_valid), 64'd0);
        ex_valid = 0;
        rst_n = 1'b1;
        tick();
        chk("rst_after_redirect_valid", 64'(redirect_valid), 64'd0);
        look(32'h200, 0, 32'h204, "rst_after_lookup");

        // narrow counters saturate
        for (int k = 0; k < 4; k++) issue(0, 0, 1, 32'h700 + 32'(4 * k), 0, 0, 1, 0);
        chk("sat_mispredict_count", 64'(mispredict_count), 64'd4);
        chk("sat_s_mispredict_count", 64'(s_mispredict_count), 64'd3);
        for (int k = 0; k < 4; k++) issue(2, 0, 8, 32'h800 + 32'(4 * k), 0, 0, 0, 0);
        chk("sat_s_branch_count", 64'(s_branch_count), 64'd3);
        chk("sat_branch_count", 64'(branch_count), 64'd4);

        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 XLEN, 32, datapath and address width; SHALL be >= 32.
REQ-002 BTB_ENTRIES, 64, BTB depth; SHALL be a power of two >= 4; IDX = log2(BTB_ENTRIES).
REQ-003 CNT_W, 32, width of the statistics counters.
REQ-004 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 if_pc  input  XLEN  fetch PC to look up.
REQ-007 pred_taken  output  1  combinational taken prediction for if_pc.
REQ-008 pred_target  output  XLEN  combinational predicted next PC for if_pc.
REQ-009 ex_valid  input  1  execute-stage instruction valid.
REQ-010 ex_instr  input  32  execute-stage RV32I instruction word.
REQ-011 ex_pc  input  XLEN  PC of ex_instr.
REQ-012 rs1, rs2  input  XLEN  source operand values.
REQ-013 ex_pred_taken, ex_pred_target  input  1 / XLEN  fetch-time prediction carried with ex_instr.
REQ-014 redirect_valid, redirect_pc  output  1 / XLEN  registered fetch redirect.
REQ-015 resolved_taken  output  1  registered actual outcome of the last resolved instruction.
REQ-016 branch_count, mispredict_count  output  CNT_W  registered statistics.

Function
REQ-017 Decode: opcode 1100011 with funct3 000/001/100/101/110/111 is BEQ/BNE/BLT/BGE/BLTU/BGEU. Opcode 1101111 is JAL. Opcode 1100111 with funct3 000 is JALR. Everything else, including branch funct3 010/011, is non-control.
REQ-018 Conditions: BLT/BGE SHALL compare signed; BLTU/BGEU SHALL compare unsigned. JAL and JALR SHALL always be taken.
REQ-019 Immediates (B, J, I) SHALL be sign-extended to XLEN.
REQ-020 Actual target: ex_pc+imm for branches and JAL; (rs1+imm) with bit 0 cleared for JALR. All sums wrap modulo 2^XLEN.
REQ-021 Actual next PC: the target if taken, else ex_pc+4 (wraps).
REQ-022 BTB entry: valid, tag = pc[XLEN-1:IDX+2], target (XLEN), 2-bit saturating counter ctr.
REQ-023 Index is pc[IDX+1:2].
REQ-024 Lookup: hit = valid and tag match. pred_taken = hit and ctr[1]. pred_target = target if pred_taken, else if_pc+4.
REQ-025 Mispredict when ex_valid=1 and either:
- control instruction: actual taken != ex_pred_taken, or taken and target != ex_pred_target;
- non-control instruction: ex_pred_taken=1.
REQ-026 On mispredict, at the next edge: redirect_valid=1, redirect_pc = actual next PC (ex_pc+4 for non-control). Otherwise redirect_valid=0 at that edge. Latency is exactly 1 cycle; redirect_valid SHALL be a single-cycle pulse per mispredict.
REQ-027 resolved_taken SHALL update only at edges where ex_valid=1 (0 for non-control) and hold otherwise.
REQ-028 Conditional branch, hit: ctr +1 if taken (saturating at 3), -1 if not taken (saturating at 0); target rewritten if taken.
REQ-029 Conditional branch, miss: if taken, allocate with ctr=2'b10 and the new tag/target; if not taken, no write.
REQ-030 JAL/JALR SHALL write valid=1, tag, target, ctr=2'b11, replacing any previous occupant.
REQ-031 Non-control instruction with ex_pred_taken=1 and a tag hit at ex_pc SHALL clear that entry's valid bit.
REQ-032 ex_valid=0 SHALL cause no BTB, counter or redirect change (redirect_valid=0 next cycle).
REQ-033 Same-cycle lookup and update of the same entry: lookup SHALL return the pre-update contents; the new contents are visible from the next cycle.
REQ-034 branch_count SHALL increment per valid control instruction; mispredict_count SHALL increment per mispredict. Both saturate at all-ones.

Reset
REQ-035 rst_n=0 SHALL immediately, regardless of clk, clear: every valid bit, redirect_valid, redirect_pc, resolved_taken, both counters.
REQ-036 BTB tag, target and ctr fields need no reset.
REQ-037 Reset mid-resolve SHALL discard the pending redirect; the first edge after release SHALL behave as if no prior history existed.

Verification
REQ-038 After reset, if_pc=0x100 -> pred_taken=0, pred_target=0x104. Then BEQ at 0x100, rs1=rs2=5, imm=+0x40, ex_pred_taken=0 -> next cycle redirect_valid=1, redirect_pc=0x140, mispredict_count=1, branch_count=1.
REQ-039 Same BEQ again with the now-hit prediction (taken, 0x140) -> no redirect, ctr=3. Then rs1=1, rs2=2 with ex_pred_taken=1 -> redirect_pc=0x104, ctr=2, pred_taken still 1.
REQ-040 BLT rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU with the same operands -> not taken; resolved_taken matches each.
REQ-041 JALR at 0x200, rs1=0x1001, imm=+2, ex_pred_taken=0 -> redirect_pc=0x1002. Re-lookup of 0x200 -> pred_taken=1, pred_target=0x1002.
REQ-042 ADDI at 0x300 with ex_pred_taken=1 -> redirect_pc=0x304 and the entry is invalidated. Separately, assert rst_n=0 between ex_valid and the next edge -> redirect_valid never asserts.
REQ-043 Force mispredict_count to all-ones, then mispredict -> count holds all-ones.
